// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/data memory handshake bundle
// between the control sequencer and the memory ports.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack,
    input  instr
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack,
    output instr
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32 multi-cycle control sequencer with
// bus-timeout / illegal-opcode traps and a retired-instruction count.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int U_EN    = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             trap_clr,
  input  logic             branch_taken,
  multicycle_ctrl_if.master bus,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic             alu_a_pc,
  output logic             mem_to_reg,
  output logic             jump,
  output logic             branch,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LD, C_ST, C_BR, C_JAL, C_JALR
  } cls_t;

  localparam logic       UEN     = (U_EN != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     ret_st;
  cls_t       cls;
  logic [7:0] tcnt;

  cls_t       d_cls;
  logic       d_legal;
  logic       d_src;
  logic       d_apc;
  logic       d_m2r;
  logic       d_jump;
  logic       d_br;
  logic [1:0] d_op;

  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       unused_hi;

  assign unused_hi = ^bus.instr[31:7];
  assign ret_st    = run ? S_FETCH : S_IDLE;

  always_comb begin
    d_legal = 1'b1;
    d_cls   = C_ALU;
    d_src   = 1'b0;
    d_apc   = 1'b0;
    d_m2r   = 1'b0;
    d_jump  = 1'b0;
    d_br    = 1'b0;
    d_op    = 2'b00;
    unique case (bus.instr[6:0])
      7'b0110011: d_op = 2'b10;
      7'b0010011: begin
        d_src = 1'b1;
        d_op  = 2'b10;
      end
      7'b0000011: begin
        d_cls = C_LD;
        d_src = 1'b1;
        d_m2r = 1'b1;
      end
      7'b0100011: begin
        d_cls = C_ST;
        d_src = 1'b1;
      end
      7'b1100011: begin
        d_cls = C_BR;
        d_br  = 1'b1;
        d_op  = 2'b01;
      end
      7'b1101111: begin
        d_cls  = C_JAL;
        d_jump = 1'b1;
      end
      7'b1100111: begin
        d_cls  = C_JALR;
        d_jump = 1'b1;
        d_src  = 1'b1;
      end
      7'b0110111: begin
        d_legal = UEN;
        d_src   = 1'b1;
        d_op    = 2'b11;
      end
      7'b0010111: begin
        d_legal = UEN;
        d_src   = 1'b1;
        d_apc   = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
    // an illegal opcode leaves every decode control cleared
    if (!d_legal) begin
      d_cls  = C_ALU;
      d_src  = 1'b0;
      d_apc  = 1'b0;
      d_m2r  = 1'b0;
      d_jump = 1'b0;
      d_br   = 1'b0;
      d_op   = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cls        <= C_ALU;
      tcnt       <= '0;
      trap_cause <= 2'b00;
      instret    <= '0;
      alu_src    <= 1'b0;
      alu_a_pc   <= 1'b0;
      mem_to_reg <= 1'b0;
      jump       <= 1'b0;
      branch     <= 1'b0;
      alu_op     <= 2'b00;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            tcnt  <= '0;
          end
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            state <= S_DECODE;
          end else if (tcnt == TO_LAST) begin
            state      <= S_TRAP;
            trap_cause <= 2'b01;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_DECODE: begin
          cls        <= d_cls;
          alu_src    <= d_src;
          alu_a_pc   <= d_apc;
          mem_to_reg <= d_m2r;
          jump       <= d_jump;
          branch     <= d_br;
          alu_op     <= d_op;
          if (d_legal) begin
            state <= S_EXEC;
          end else begin
            state      <= S_TRAP;
            trap_cause <= 2'b11;
          end
        end
        S_EXEC: begin
          unique case (cls)
            C_LD, C_ST: begin
              state <= S_MEM;
              tcnt  <= '0;
            end
            C_BR: begin
              state   <= ret_st;
              tcnt    <= '0;
              instret <= instret + CNT_W'(1);
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (cls == C_ST) begin
              state   <= ret_st;
              tcnt    <= '0;
              instret <= instret + CNT_W'(1);
            end else begin
              state <= S_WB;
            end
          end else if (tcnt == TO_LAST) begin
            state      <= S_TRAP;
            trap_cause <= 2'b10;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WB: begin
          state   <= ret_st;
          tcnt    <= '0;
          instret <= instret + CNT_W'(1);
        end
        S_TRAP: begin
          if (trap_clr) begin
            state      <= S_IDLE;
            trap_cause <= 2'b00;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // strobes follow the same-cycle acks and branch result
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_write = 1'b0;
    pc_src    = 2'b00;
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = bus.imem_ack;
      end
      S_EXEC: begin
        if (cls == C_BR) begin
          pc_we  = 1'b1;
          pc_src = {1'b0, branch_taken};
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_ST);
        pc_we    = bus.dmem_ack && (cls == C_ST);
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        unique case (1'b1)
          cls == C_JAL:  pc_src = 2'b01;
          cls == C_JALR: pc_src = 2'b10;
          default:       pc_src = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign busy = (state != S_IDLE) && (state != S_TRAP);
  assign trap = (state == S_TRAP);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32 cores; the next generation of the combinational opcode decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memory, and holds decoded control signals in registers. It adds LUI/AUIPC support, bus-timeout and illegal-opcode traps, and a retired-instruction counter. One instance sits per core, between the memory ports and the register file/ALU datapath.

## Interface
- `TIMEOUT`, 15: max cycles waiting for `imem_ack`/`dmem_ack` before a trap (1..255).
- `U_EN`, 1: 1 = LUI/AUIPC are legal; 0 = they decode as illegal.
- `CNT_W`, 32: width of `instret`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  enable; sampled in IDLE and at instruction retirement.
- `trap_clr`  in  1  leaves TRAP to IDLE.
- `instr`  in  32  instruction register contents (datapath IR, written on `ir_we`).
- `branch_taken`  in  1  comparator result from datapath, valid in EXEC.
- `imem_req` / `imem_ack`  out / in  1  instruction fetch handshake.
- `dmem_req` / `dmem_we` / `dmem_ack`  out / out / in  1  data access handshake.
- `ir_we`, `pc_we`, `reg_write`  out  1  single-cycle strobes.
- `pc_src`  out  2  00 PC+4, 01 PC+imm, 10 ALU result.
- `alu_src`, `alu_a_pc`, `mem_to_reg`, `jump`, `branch`  out  1  registered decode.
- `alu_op`  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 pass-imm.
- `busy`  out  1  state != IDLE and != TRAP.
- `trap`  out  1  high in TRAP.
- `trap_cause`  out  2  01 fetch timeout, 10 data timeout, 11 illegal opcode.
- `instret`  out  CNT_W  retired instruction count; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset: state IDLE. All outputs 0, including `trap_cause`, `instret` and all registered decode outputs.
- IDLE: if `run`=1, go to FETCH.
- FETCH:
  - `imem_req`=1 while waiting.
  - On `imem_ack`: `ir_we`=1 that cycle, go to DECODE.
- DECODE: decode `instr[6:0]` into registered controls.
  - R (0110011): reg_write, alu_op 10.
  - I (0010011): reg_write, alu_src, alu_op 10.
  - LOAD (0000011): alu_src, mem_to_reg, alu_op 00.
  - STORE (0100011): alu_src, alu_op 00.
  - BRANCH (1100011): branch, alu_op 01.
  - JAL (1101111): jump.
  - JALR (1100111): jump, alu_src.
  - LUI (0110111): alu_src, alu_op 11.
  - AUIPC (0010111): alu_src, alu_a_pc, alu_op 00.
  - Any other opcode, or LUI/AUIPC with U_EN=0: go to TRAP, cause 11. Otherwise go to EXEC.
- EXEC (always 1 cycle):
  - LOAD/STORE go to MEM.
  - BRANCH: `pc_we`=1, `pc_src`=01 if `branch_taken` else 00; retire.
  - All other opcodes go to WB.
- MEM:
  - `dmem_req`=1 while waiting; `dmem_we`=1 for STORE.
  - On ack: STORE asserts `pc_we` (pc_src 00) and retires; LOAD goes to WB.
- WB:
  - `reg_write`=1 and `pc_we`=1 for one cycle.
  - `pc_src`: JAL 01, JALR 10, else 00. Retire.
- Retire:
  - `instret` += 1.
  - Next state is FETCH if `run`=1, else IDLE.
- TRAP:
  - All strobes and request outputs are 0.
  - `trap_cause` is held; on `trap_clr` go to IDLE and clear `trap_cause`.
- Registered decode outputs keep their values from DECODE until the next DECODE. The `reg_write` strobe is only ever asserted in WB.

## Timing
- Latency with single-cycle ack:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles (F, D, E, W).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on a memory ack adds 1 cycle.
- Timeout counter:
  - Cleared on entry to FETCH or MEM; increments each cycle without ack.
  - On reaching TIMEOUT with no ack: go to TRAP with cause 01 (FETCH) or 10 (MEM).
  - If ack arrives in the same cycle the count reaches TIMEOUT, the ack wins.
- `imem_req`/`dmem_req` stay high until the ack cycle inclusive, then drop. Acks arriving in any other state are ignored.
- `run` deasserted mid-instruction: the instruction completes, then the FSM enters IDLE.
- `trap_clr` outside TRAP: ignored.
- `rst_n` low mid-instruction: immediate return to IDLE. No strobe fires, and `instret` clears.

## Test plan
- Reset, run=1, R-type 0x002081B3, acks on the first cycle → `ir_we`, then `reg_write`+`pc_we` (pc_src 00) exactly 4 cycles after run; `instret`=1.
- LW with `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_we`=0, `mem_to_reg`=1, WB at cycle 8; BEQ with `branch_taken`=1 → `pc_we`, `pc_src`=01 in cycle 3, no `reg_write`.
- Opcode 0x7F, and LUI with U_EN=0 → TRAP, `trap_cause`=11, `instret` unchanged; `trap_clr` → IDLE, cause 00.
- TIMEOUT=4, `imem_ack` never → TRAP, cause 01 after 4 FETCH cycles; repeat with ack in the 4th cycle → no trap.
- JALR then run=0 during EXEC → `pc_src`=10 in WB, then IDLE; `instret` incremented once.
- CNT_W=4, 16 retirements → `instret` wraps to 0; `rst_n` low during MEM → all outputs 0 asynchronously.
